// File: rtl/mips_single_cycle.sv
// mips_single_cycle: single-cycle 32-bit MIPS subset CPU.
//
// Supported instructions: add, sub, and, or, slt (R-type), lw, sw, beq,
// addi and j. Every instruction completes in one clock. Any other opcode
// decodes with all controls low. It writes nothing, stores nothing and the
// PC advances by 4.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; forces PC to 0 and leaves
//              register file and memories untouched
//   PCNext, PC, PCplus4, Instr, Signlmm, shifted, PCBranch,
//   ReadData1, ReadData2, SrcB, ALUResult, ReadData, Result, WriteReg
//              datapath nets exported for debug/observation
//   RegWrite, RegDst, MemtoReg, MemWrite, Branch, ALUSrc, Jump,
//   ALUControl, Zero, PCSrc
//              decoded control nets exported for debug/observation
//
// Sub-blocks (instance names are stable so memories can be preloaded
// hierarchically): im (mips_imem, array Memory), rf (mips_regfile, array
// RegFile), dm (mips_dmem, array Memory).

// Instruction memory: combinational read. The write port exists only so
// the array has a driver. The CPU ties it off, and program images are
// loaded hierarchically into Memory.
module mips_imem #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  logic [31:0]   wd,
  input  logic [AW-1:0] addr,
  output logic [31:0]   rd
);
  logic [31:0] Memory [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) Memory[wa] <= wd;
  end

  assign rd = Memory[addr];
endmodule

// Register file: two combinational read ports, one write port on the
// rising edge. $0 reads as zero and is never written.
module mips_regfile (
  input  logic        clk,
  input  logic        we,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  input  logic [4:0]  wa,
  input  logic [31:0] wd,
  output logic [31:0] rd1,
  output logic [31:0] rd2
);
  logic [31:0] RegFile [0:31];

  always_ff @(posedge clk) begin
    if (we && (wa != 5'd0)) RegFile[wa] <= wd;
  end

  assign rd1 = (ra1 == 5'd0) ? 32'd0 : RegFile[ra1];
  assign rd2 = (ra2 == 5'd0) ? 32'd0 : RegFile[ra2];
endmodule

// Data memory: combinational read, write on the rising edge. It takes a
// word index, so byte-offset bits never reach it (no alignment trap).
module mips_dmem #(
  parameter int WORDS = 64,
  parameter int AW    = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wd,
  output logic [31:0]   rd
);
  logic [31:0] Memory [0:WORDS-1];

  always_ff @(posedge clk) begin
    if (we) Memory[addr] <= wd;
  end

  assign rd = Memory[addr];
endmodule

module mips_single_cycle #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] PCNext,
  output logic [31:0] PC,
  output logic [31:0] PCplus4,
  output logic [31:0] Instr,
  output logic [31:0] Signlmm,
  output logic [31:0] ReadData1,
  output logic [31:0] ReadData2,
  output logic [31:0] PCBranch,
  output logic [31:0] Result,
  output logic [31:0] SrcB,
  output logic [31:0] ALUResult,
  output logic [31:0] ReadData,
  output logic [4:0]  WriteReg,
  output logic        RegWrite,
  output logic        RegDst,
  output logic        MemtoReg,
  output logic        MemWrite,
  output logic        Branch,
  output logic        ALUSrc,
  output logic        Jump,
  output logic        Zero,
  output logic [31:0] shifted,
  output logic [2:0]  ALUControl,
  output logic        PCSrc
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  logic [1:0] ALUOp;

  // ---------------------------------------------------------------- PC
  always_ff @(posedge clk or posedge reset) begin
    if (reset) PC <= 32'd0;
    else       PC <= PCNext;
  end

  assign PCplus4  = PC + 32'd4;
  assign Signlmm  = {{16{Instr[15]}}, Instr[15:0]};
  assign shifted  = {Signlmm[29:0], 2'b00};
  assign PCBranch = PCplus4 + shifted;
  assign PCSrc    = Branch & Zero;

  // Jump takes priority over a branch. The two never decode together,
  // but the order keeps the mux well defined.
  always_comb begin
    PCNext = PCplus4;
    if (Jump)       PCNext = {PCplus4[31:28], Instr[25:0], 2'b00};
    else if (PCSrc) PCNext = PCBranch;
  end

  // ---------------------------------------------------------- memories
  mips_imem #(.WORDS(IMEM_WORDS)) im (
    .clk  (clk),
    .we   (1'b0),
    .wa   ({IAW{1'b0}}),
    .wd   (32'd0),
    .addr (PC[IAW+1:2]),
    .rd   (Instr)
  );

  mips_regfile rf (
    .clk (clk),
    .we  (RegWrite),
    .ra1 (Instr[25:21]),
    .ra2 (Instr[20:16]),
    .wa  (WriteReg),
    .wd  (Result),
    .rd1 (ReadData1),
    .rd2 (ReadData2)
  );

  mips_dmem #(.WORDS(DMEM_WORDS)) dm (
    .clk  (clk),
    .we   (MemWrite),
    .addr (ALUResult[DAW+1:2]),
    .wd   (ReadData2),
    .rd   (ReadData)
  );

  // ------------------------------------------------------ main decoder
  always_comb begin
    RegWrite = 1'b0;
    RegDst   = 1'b0;
    ALUSrc   = 1'b0;
    Branch   = 1'b0;
    MemWrite = 1'b0;
    MemtoReg = 1'b0;
    Jump     = 1'b0;
    ALUOp    = 2'b00;
    case (Instr[31:26])
      OP_RTYPE: begin RegWrite = 1'b1; RegDst = 1'b1; ALUOp = 2'b10; end
      OP_LW:    begin RegWrite = 1'b1; ALUSrc = 1'b1; MemtoReg = 1'b1; end
      OP_SW:    begin ALUSrc = 1'b1; MemWrite = 1'b1; end
      OP_BEQ:   begin Branch = 1'b1; ALUOp = 2'b01; end
      OP_ADDI:  begin RegWrite = 1'b1; ALUSrc = 1'b1; end
      OP_J:     begin Jump = 1'b1; end
      default:  ;
    endcase
  end

  // ------------------------------------------------------- ALU decoder
  always_comb begin
    ALUControl = ALU_ADD;
    case (ALUOp)
      2'b00: ALUControl = ALU_ADD;
      2'b01: ALUControl = ALU_SUB;
      default: begin
        case (Instr[5:0])
          6'b100000: ALUControl = ALU_ADD;
          6'b100010: ALUControl = ALU_SUB;
          6'b100100: ALUControl = ALU_AND;
          6'b100101: ALUControl = ALU_OR;
          6'b101010: ALUControl = ALU_SLT;
          default:   ALUControl = ALU_ADD;
        endcase
      end
    endcase
  end

  // ---------------------------------------------------- datapath + ALU
  assign WriteReg = RegDst ? Instr[15:11] : Instr[20:16];
  assign SrcB     = ALUSrc ? Signlmm : ReadData2;

  always_comb begin
    ALUResult = 32'd0;
    case (ALUControl)
      ALU_ADD: ALUResult = ReadData1 + SrcB;
      ALU_SUB: ALUResult = ReadData1 - SrcB;
      ALU_AND: ALUResult = ReadData1 & SrcB;
      ALU_OR:  ALUResult = ReadData1 | SrcB;
      ALU_SLT: ALUResult = {31'd0, $signed(ReadData1) < $signed(SrcB)};
      default: ALUResult = 32'd0;
    endcase
  end

  assign Zero   = (ALUResult == 32'd0);
  assign Result = MemtoReg ? ReadData : ALUResult;
endmodule

// File: tb/tb_mips_single_cycle.sv
// tb_mips_single_cycle: bench for mips_single_cycle.
// Runs a preloaded program twice: once with $2=2 (beq falls through into
// a j-to-self loop), then after a mid-run reset pulse with $2=1 (beq taken
// into an ALU/addi/unknown-opcode/$0 sequence). Each step's expected
// outputs come from a hand-computed vector table through a scoreboard queue.
module tb_mips_single_cycle;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] PCNext, PC, PCplus4, Instr, Signlmm, ReadData1, ReadData2;
  logic [31:0] PCBranch, Result, SrcB, ALUResult, ReadData, shifted;
  logic [4:0]  WriteReg;
  logic        RegWrite, RegDst, MemtoReg, MemWrite, Branch, ALUSrc, Jump;
  logic        Zero, PCSrc;
  logic [2:0]  ALUControl;

  // ---------------------------------------------------- clock / reset
  always #5 clk = ~clk;

  mips_single_cycle dut (
    .clk(clk), .reset(reset), .PCNext(PCNext), .PC(PC), .PCplus4(PCplus4),
    .Instr(Instr), .Signlmm(Signlmm), .ReadData1(ReadData1),
    .ReadData2(ReadData2), .PCBranch(PCBranch), .Result(Result), .SrcB(SrcB),
    .ALUResult(ALUResult), .ReadData(ReadData), .WriteReg(WriteReg),
    .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
    .MemWrite(MemWrite), .Branch(Branch), .ALUSrc(ALUSrc), .Jump(Jump),
    .Zero(Zero), .shifted(shifted), .ALUControl(ALUControl), .PCSrc(PCSrc)
  );

  // ctrl = {RegWrite, RegDst, ALUSrc, Branch, MemWrite, MemtoReg, Jump}
  localparam logic [6:0] C_R   = 7'b1100000;
  localparam logic [6:0] C_LW  = 7'b1010010;
  localparam logic [6:0] C_SW  = 7'b0010100;
  localparam logic [6:0] C_BEQ = 7'b0001000;
  localparam logic [6:0] C_ADI = 7'b1010000;
  localparam logic [6:0] C_J   = 7'b0000001;
  localparam logic [6:0] C_NO  = 7'b0000000;

  // chk: 0 none, 1 register file word, 2 data memory word
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] alu;
    logic [31:0] result;
    logic [4:0]  wreg;
    logic [6:0]  ctrl;
    logic [2:0]  aluc;
    logic        zero;
    logic        pcsrc;
    logic [1:0]  chk;
    logic [5:0]  chk_idx;
    logic [31:0] chk_val;
  } vec_t;
  localparam int W = $bits(vec_t);

  logic [W-1:0] exp_q[$];
  vec_t         vecs1 [0:5];
  vec_t         vecs2 [0:14];
  logic [31:0]  prog  [0:63];
  int           n_cmp  = 0;
  int           n_fail = 0;

  function automatic vec_t mk(input logic [31:0] pc, pcn, alu, res,
                              input logic [4:0] wr, input logic [6:0] ct,
                              input logic [2:0] ac, input logic z, ps,
                              input logic [1:0] ck, input logic [5:0] ci,
                              input logic [31:0] cv);
    vec_t v;
    v.pc = pc; v.pc_next = pcn; v.alu = alu; v.result = res; v.wreg = wr;
    v.ctrl = ct; v.aluc = ac; v.zero = z; v.pcsrc = ps;
    v.chk = ck; v.chk_idx = ci; v.chk_val = cv;
    return v;
  endfunction

  // ------------------------------------------------------- scoreboard
  task automatic check(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  // Drive one step: queue its expectation, let outputs settle, then pop
  // and compare against what the DUT shows for the current PC.
  task automatic run_vec(input vec_t v, input int idx);
    vec_t e;
    exp_q.push_back(v);
    #1;
    if (exp_q.size() == 0) begin
      check("queue_empty", idx, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      check("PC",         idx, PC,         e.pc);
      check("PCNext",     idx, PCNext,     e.pc_next);
      check("ALUResult",  idx, ALUResult,  e.alu);
      check("Result",     idx, Result,     e.result);
      check("WriteReg",   idx, {27'd0, WriteReg}, {27'd0, e.wreg});
      check("ctrl",       idx, {25'd0, RegWrite, RegDst, ALUSrc, Branch,
                                MemWrite, MemtoReg, Jump}, {25'd0, e.ctrl});
      check("ALUControl", idx, {29'd0, ALUControl}, {29'd0, e.aluc});
      check("Zero_PCSrc", idx, {30'd0, Zero, PCSrc}, {30'd0, e.zero, e.pcsrc});
      if (e.chk == 2'd1)
        check("rf_word", idx, dut.rf.RegFile[e.chk_idx[4:0]], e.chk_val);
      else if (e.chk == 2'd2)
        check("dmem_word", idx, dut.dm.Memory[e.chk_idx], e.chk_val);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ------------------------------------------------------------- test
  initial begin
    for (int k = 0; k < 64; k++) prog[k] = 32'd0;
    prog[0]  = 32'h00221820; // add  $3,$1,$2
    prog[1]  = 32'h8C240004; // lw   $4,4($1)
    prog[2]  = 32'hAC250008; // sw   $5,8($1)
    prog[3]  = 32'h10220002; // beq  $1,$2,2
    prog[4]  = 32'h08000004; // j    4
    prog[6]  = 32'h00253022; // sub  $6,$1,$5
    prog[7]  = 32'h00853825; // or   $7,$4,$5
    prog[8]  = 32'h00C1402A; // slt  $8,$6,$1
    prog[9]  = 32'h2009FFFF; // addi $9,$0,-1
    prog[10] = 32'h0029502A; // slt  $10,$1,$9
    prog[11] = 32'h01255824; // and  $11,$9,$5
    prog[12] = 32'hFC000000; // unknown opcode
    prog[13] = 32'h00220020; // add  $0,$1,$2
    prog[14] = 32'h00016820; // add  $13,$0,$1
    prog[15] = 32'h0800000F; // j    15

    //             pc      pcnext  alu           result        wr  ctrl   aluc    z  ps chk idx val
    vecs1[0] = mk(32'h00, 32'h04, 32'd3,        32'd3,        3, C_R,   3'b010, 0, 0, 0, 0, 0);
    vecs1[1] = mk(32'h04, 32'h08, 32'd5,        32'h77,       4, C_LW,  3'b010, 0, 0, 1, 3, 3);
    vecs1[2] = mk(32'h08, 32'h0C, 32'd9,        32'd9,        5, C_SW,  3'b010, 0, 0, 1, 4, 32'h77);
    vecs1[3] = mk(32'h0C, 32'h10, 32'hFFFFFFFF, 32'hFFFFFFFF, 2, C_BEQ, 3'b110, 0, 0, 2, 2, 5);
    vecs1[4] = mk(32'h10, 32'h10, 32'd0,        32'd0,        0, C_J,   3'b010, 1, 0, 0, 0, 0);
    vecs1[5] = mk(32'h10, 32'h10, 32'd0,        32'd0,        0, C_J,   3'b010, 1, 0, 0, 0, 0);

    vecs2[0]  = mk(32'h00, 32'h04, 32'd2,        32'd2,        3,  C_R,   3'b010, 0, 0, 0, 0, 0);
    vecs2[1]  = mk(32'h04, 32'h08, 32'd5,        32'h77,       4,  C_LW,  3'b010, 0, 0, 1, 3, 2);
    vecs2[2]  = mk(32'h08, 32'h0C, 32'd9,        32'd9,        5,  C_SW,  3'b010, 0, 0, 0, 0, 0);
    vecs2[3]  = mk(32'h0C, 32'h18, 32'd0,        32'd0,        2,  C_BEQ, 3'b110, 1, 1, 2, 2, 5);
    vecs2[4]  = mk(32'h18, 32'h1C, 32'hFFFFFFFC, 32'hFFFFFFFC, 6,  C_R,   3'b110, 0, 0, 0, 0, 0);
    vecs2[5]  = mk(32'h1C, 32'h20, 32'h77,       32'h77,       7,  C_R,   3'b001, 0, 0, 0, 0, 0);
    vecs2[6]  = mk(32'h20, 32'h24, 32'd1,        32'd1,        8,  C_R,   3'b111, 0, 0, 1, 6, 32'hFFFFFFFC);
    vecs2[7]  = mk(32'h24, 32'h28, 32'hFFFFFFFF, 32'hFFFFFFFF, 9,  C_ADI, 3'b010, 0, 0, 1, 8, 1);
    vecs2[8]  = mk(32'h28, 32'h2C, 32'd0,        32'd0,        10, C_R,   3'b111, 1, 0, 1, 9, 32'hFFFFFFFF);
    vecs2[9]  = mk(32'h2C, 32'h30, 32'd5,        32'd5,        11, C_R,   3'b000, 0, 0, 1, 10, 0);
    vecs2[10] = mk(32'h30, 32'h34, 32'd0,        32'd0,        0,  C_NO,  3'b010, 1, 0, 1, 11, 5);
    vecs2[11] = mk(32'h34, 32'h38, 32'd2,        32'd2,        0,  C_R,   3'b010, 0, 0, 1, 7, 32'h77);
    vecs2[12] = mk(32'h38, 32'h3C, 32'd1,        32'd1,        13, C_R,   3'b010, 0, 0, 0, 0, 0);
    vecs2[13] = mk(32'h3C, 32'h3C, 32'd0,        32'd0,        0,  C_J,   3'b010, 1, 0, 1, 13, 1);
    vecs2[14] = mk(32'h3C, 32'h3C, 32'd0,        32'd0,        0,  C_J,   3'b010, 1, 0, 0, 0, 0);

    reset = 1'b1;
    for (int k = 0; k < 64; k++) begin
      dut.im.Memory[k] <= prog[k];
      dut.dm.Memory[k] <= 32'd0;
    end
    for (int k = 0; k < 32; k++) dut.rf.RegFile[k] <= 32'd0;
    for (int k = 1; k <= 5; k++) dut.rf.RegFile[k] <= k;
    dut.rf.RegFile[10] <= 32'hAA;
    dut.dm.Memory[1]   <= 32'h77;

    // Reset state, before and across a clock edge.
    #1;
    check("reset_PC",    0, PC,    32'd0);
    check("reset_Instr", 0, Instr, 32'h00221820);
    @(negedge clk);
    check("reset_hold_PC", 0, PC, 32'd0);
    reset = 1'b0;

    // Pass 1: $2=2, beq falls through, j loops on itself.
    for (int i = 0; i < 6; i++) begin
      run_vec(vecs1[i], i);
      if (i == 1) check("lw_ReadData",  i, ReadData,  32'h77);
      if (i == 2) check("sw_ReadData2", i, ReadData2, 32'd5);
      if (i == 3) check("beq_PCBranch", i, PCBranch,  32'h18);
      @(negedge clk);
    end

    // Reset pulse between edges: PC clears at once, state is retained.
    #1;
    dut.rf.RegFile[2] <= 32'd1;
    reset = 1'b1;
    #1;
    check("midreset_PC",    0, PC,    32'd0);
    check("midreset_Instr", 0, Instr, 32'h00221820);
    check("midreset_rf3",   0, dut.rf.RegFile[3], 32'd3);
    check("midreset_dmem2", 0, dut.dm.Memory[2],  32'd5);
    reset = 1'b0;

    // Pass 2: $2=1, beq taken to 0x18 and on through the ALU sequence.
    for (int i = 0; i < 15; i++) begin
      run_vec(vecs2[i], 100 + i);
      if (i == 3) check("beq_taken_PCBranch", i, PCBranch, 32'h18);
      @(negedge clk);
    end

    check("queue_drained", 0, exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/mips_single_cycle.md
Name: mips_single_cycle

Overview:
- Single-cycle 32-bit MIPS subset processor: PC register, instruction memory, register file, sign extender, ALU, data memory and main/ALU decoders in one block.
- Every instruction completes in one clock.
- All key datapath and control nets are exported as outputs for waveform/debug observation.
- Top-level CPU of the design; no external memory bus.

Parameters:
- IMEM_WORDS, 64, instruction memory depth in 32-bit words, word index = PC[7:2].
- DMEM_WORDS, 64, data memory depth in 32-bit words, word index = ALUResult[7:2].

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; forces PC to 0.
- PCNext, PC, PCplus4  out  32 each  next PC, current PC, PC+4.
- Instr  out  32  current instruction.
- Signlmm  out  32  sign-extended Instr[15:0].
- ReadData1, ReadData2  out  32 each  register file read ports (rs, rt).
- PCBranch  out  32  PCplus4 + shifted.
- Result  out  32  register write-back data.
- SrcB  out  32  ALU operand B.
- ALUResult  out  32  ALU output, also the data address.
- ReadData  out  32  data memory read data.
- WriteReg  out  5  destination register.
- RegWrite, RegDst, MemtoReg, MemWrite, Branch, ALUSrc, Jump  out  1 each  decoded controls.
- Zero  out  1  ALUResult == 0.
- shifted  out  32  Signlmm << 2.
- ALUControl  out  3  ALU operation.
- PCSrc  out  1  Branch & Zero.

Behaviour:
- Clock and reset: one clock (clk); reset asynchronous, active-high.
  - reset=1 sets PC=0 immediately.
  - All outputs are combinational from PC and state.
  - Register file and both memories are not cleared by reset, so contents are preloadable.
- Required submodule instance names:
  - im: instruction memory, array Memory.
  - rf: register file, array RegFile[0:31].
  - Benches preload these hierarchically.
- Instruction memory: combinational read, Instr = im.Memory[PC[7:2]]; unwritten words read 0, which decodes as R-type funct 0 = no-op write of $0.
- Register file:
  - Two combinational read ports.
  - Write on rising clk when RegWrite=1.
  - $0 always reads 0; writes to $0 are ignored.
- Data memory: combinational read; write on rising clk when MemWrite=1; low address bits [1:0] ignored (no alignment trap).
- Main decoder, by opcode (RegWrite RegDst ALUSrc Branch MemWrite MemtoReg Jump ALUOp):
  - R-type 000000 = 1 1 0 0 0 0 0 10
  - lw 100011 = 1 0 1 0 0 1 0 00
  - sw 101011 = 0 x→0 1 0 1 0 0 00
  - beq 000100 = 0 0 0 1 0 0 0 01
  - addi 001000 = 1 0 1 0 0 0 0 00
  - j 000010 = 0 0 0 0 0 0 1 00
  - Any other opcode: all controls 0 (no state change, PC+4).
- ALU decoder:
  - ALUOp 00 → 010 (add).
  - ALUOp 01 → 110 (sub).
  - ALUOp 10, by funct: 100000 add → 010; 100010 sub → 110; 100100 and → 000; 100101 or → 001; 101010 slt → 111; other funct → 010.
- ALU: 32-bit, wraparound arithmetic, no overflow trap; slt is signed and yields 1 or 0.
- Datapath:
  - WriteReg = RegDst ? Instr[15:11] : Instr[20:16].
  - SrcB = ALUSrc ? Signlmm : ReadData2.
  - Result = MemtoReg ? ReadData : ALUResult.
- Next PC:
  - Jump: {PCplus4[31:28], Instr[25:0], 2'b00}.
  - Else PCSrc: PCBranch.
  - Else: PCplus4.
  - PC loads PCNext on rising clk when reset=0.
- Simultaneous events: a lw/add writing a register read by the same instruction uses the old value (write at edge). Reset asserted mid-program: PC=0 at once; memories and registers retained.

Test Plan:
- Preload rf[1..5]=1..5; im[0] add $3,$1,$2 → ALUResult=3, RegWrite=1, WriteReg=3, after edge rf[3]=3, PC=0x4.
- im[1] lw $4,4($1) → ALUResult=5, ALUSrc=1, MemtoReg=1, WriteReg=4, rf[4]=dmem word 1; PC=0x8.
- im[2] sw $5,8($1) → MemWrite=1, ALUResult=9, ReadData2=5, dmem word 2 = 5 after edge, RegWrite=0.
- im[3] beq $1,$2,2 → ALUControl=110, Zero=0, PCSrc=0, PCBranch=0x18, PCNext=0x10. Repeat with rf[2]=1 → PCSrc=1, PC=0x18.
- im[4] j 4 → Jump=1, PCNext=0x10; PC stays at 0x10 each cycle.
- Assert reset mid-run (between edges) → PC=0 immediately; rf and dmem contents unchanged; execution restarts at im[0].
